ysyx_041514_clint: RTL and testbench
====================================

// Module: ysyx_041514_clint
// PURPOSE
//   Responder end of the memory-stage CLINT port. It holds the machine timer
//   registers mtime and mtimecmp and serves single-cycle reads and writes
//   from the mem stage. It also raises the machine timer interrupt toward the
//   CSR/trap unit.
//   Reads are combinational, because the mem stage consumes clint_rdata with no
//   ready handshake and does not stall. Writes commit on the clock edge.
// PARAMETERS
//   MTIME_ADDR     32'h0200_BFF8          byte address of 64-bit mtime
//   MTIMECMP_ADDR  32'h0200_4000          byte address of 64-bit mtimecmp
//   TICK_DIV       1                      clk cycles per mtime increment (>=1)
//   CMP_RST        64'hFFFF_FFFF_FFFF_FFFF mtimecmp reset value (no spurious irq)
// PORTS
//   clk                  in   1   core clock
//   rst                  in   1   asynchronous reset, active-high
//   clint_addr_i         in   32  access address from mem stage
//   clint_valid_i        in   1   access valid (addr hits MTIME/MTIMECMP)
//   clint_write_valid_i  in   1   1: store, 0: load (qualified by valid)
//   clint_wdata_i        in   64  store data, unshifted, zero-extended to size
//   clint_rdata_o        out  64  load data, combinational
//   mtip_o               out  1   machine timer interrupt pending, registered
//   mtime_o              out  64  current mtime (time CSR shadow / debug)
// BEHAVIOUR
//   Reset (async, rst=1): mtime=0, mtimecmp=CMP_RST, prescaler=0, mtip_o=0.
//     All outputs are stable at these values while rst is held.
//     Deasserting rst mid-run restarts counting from 0.
//   Decode: hit_t = valid & (addr==MTIME_ADDR); hit_c = valid & (addr==MTIMECMP_ADDR).
//     Any other address while valid: read returns 0, write is ignored (no trap).
//   Read: clint_rdata_o = hit_t ? mtime : hit_c ? mtimecmp : 64'b0.
//     Output is pure combinational, 0-cycle latency, and is driven from the
//     current register state. A same-cycle write is not forwarded (old value).
//   Write: on posedge when valid & write_valid. The full 64-bit wdata replaces
//     the target register; no byte mask is applied. A store of the same value
//     repeated on consecutive cycles is idempotent for mtimecmp. For mtime, the
//     repeated store reloads the value and freezes the count; the mem stage
//     presents a store for exactly one cycle.
//   Prescaler: counter 0..TICK_DIV-1. tick = (cnt==TICK_DIV-1). On tick, cnt
//     goes to 0; otherwise cnt+1. With TICK_DIV=1, tick is asserted every cycle.
//   mtime update priority, per cycle:
//     1. write hit_t: mtime <= wdata, and the prescaler clears to 0.
//     2. tick: mtime <= mtime + 1. The increment wraps modulo 2^64
//        (all-ones -> 0), with no carry out.
//     3. otherwise: hold.
//   mtimecmp: changes only on a write hit_c and is unaffected by tick.
//   mtip_o <= (mtime >= mtimecmp), an unsigned 64-bit compare of the current
//     register values. It therefore lags the register state by 1 cycle.
//     It is level, not pulse: it stays high until software raises mtimecmp
//     or rewrites mtime.
//   mtime_o = mtime register (no extra latency).
//   Simultaneous events:
//     - Write mtimecmp together with a tick: both updates apply in the same edge.
//     - Write hit_t together with a tick: the written value wins and no
//       increment is applied.
//   No multi-cycle state: one request is served per cycle, with no backpressure.
// TESTING
//   1. Reset: hold rst 3 cycles, then release.
//      -> mtime_o 0,1,2 on the following cycles, rdata(MTIMECMP)=all-ones, mtip_o=0.
//   2. Write MTIMECMP=5, TICK_DIV=1.
//      -> mtip_o=0 while mtime<5. mtip_o rises 1 cycle after mtime_o==5 and stays high.
//   3. Store MTIME=64'hFFFF_FFFF_FFFF_FFFE.
//      -> next cycles mtime_o=..FFFE, ..FFFF, 0 (wrap). mtip_o follows the compare.
//   4. Same-cycle read and write of MTIME (wdata=100).
//      -> rdata_o = old mtime that cycle. Next cycle mtime_o=100 (no +1 on write edge).
//   5. TICK_DIV=4: mtime advances once per 4 cycles. A write to mtime mid-period
//      restarts the count, so the next increment comes 4 cycles after the write.
//   6. Access to 32'h0200_0000 with valid=1, load then store.
//      -> rdata_o=0, mtime/mtimecmp unchanged. Assert rst mid-count -> all state
//         returns to reset values immediately (async).

Source files
------------

// File: rtl/ysyx_041514_clint_if.sv
// Memory-stage CLINT access port: the mem stage is the master, the CLINT is the slave.
// The slave sees the request and returns the combinational read data in the same cycle.
interface ysyx_041514_clint_if;
  logic [31:0] clint_addr_i;
  logic        clint_valid_i;
  logic        clint_write_valid_i;
  logic [63:0] clint_wdata_i;
  logic [63:0] clint_rdata_o;

  modport master (
    output clint_addr_i,
    output clint_valid_i,
    output clint_write_valid_i,
    output clint_wdata_i,
    input  clint_rdata_o
  );

  modport slave (
    input  clint_addr_i,
    input  clint_valid_i,
    input  clint_write_valid_i,
    input  clint_wdata_i,
    output clint_rdata_o
  );
endinterface

// File: rtl/ysyx_041514_clint.sv
// Machine timer (mtime/mtimecmp) with a prescaled tick and a registered timer interrupt.
// Reads are combinational from current state; writes commit on the clock edge.
module ysyx_041514_clint #(
  parameter logic [31:0] MTIME_ADDR    = 32'h0200_BFF8,
  parameter logic [31:0] MTIMECMP_ADDR = 32'h0200_4000,
  parameter int unsigned TICK_DIV      = 1,
  parameter logic [63:0] CMP_RST       = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_041514_clint_if.slave         bus,
  output logic                       mtip_o,
  output logic [63:0]                mtime_o
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      mtimecmp_q, mtimecmp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mtip_q, mtip_d;

  logic hit_t, hit_c, wr_t, wr_c, tick;

  assign hit_t = bus.clint_valid_i && (bus.clint_addr_i == MTIME_ADDR);
  assign hit_c = bus.clint_valid_i && (bus.clint_addr_i == MTIMECMP_ADDR);
  assign wr_t  = hit_t && bus.clint_write_valid_i;
  assign wr_c  = hit_c && bus.clint_write_valid_i;
  assign tick  = (cnt_q == CNT_W'(TICK_DIV - 1));

  // Same-cycle stores are not forwarded: the mem stage sees the pre-edge value.
  assign bus.clint_rdata_o = hit_t ? mtime_q :
                             hit_c ? mtimecmp_q : 64'b0;

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    cnt_d      = cnt_q;
    if (wr_t) begin
      // A store to mtime wins over a coincident tick and restarts the period.
      mtime_d = bus.clint_wdata_i;
      cnt_d   = '0;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
      cnt_d   = '0;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
    end
    if (wr_c) begin
      mtimecmp_d = bus.clint_wdata_i;
    end
    mtip_d = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= CMP_RST;
      cnt_q      <= '0;
      mtip_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      cnt_q      <= cnt_d;
      mtip_q     <= mtip_d;
    end
  end

  assign mtip_o  = mtip_q;
  assign mtime_o = mtime_q;

endmodule

// File: tb/tb_ysyx_041514_clint.sv
// Randomized + directed bench for the CLINT, run on a TICK_DIV=1 and a TICK_DIV=4 instance
// sharing the same request stream, each checked against an elapsed-cycle reference model.
module tb_ysyx_041514_clint;

  localparam logic [31:0] MT   = 32'h0200_BFF8;
  localparam logic [31:0] MC   = 32'h0200_4000;
  localparam logic [31:0] NONE = 32'h0200_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        valid;
  logic        wv;
  logic [63:0] wdata;
  logic        mtip1, mtip4;
  logic [63:0] mtime1, mtime4;

  int n_cmp;
  int n_err;
  int cyc_n;

  // Reference state: index 0 -> TICK_DIV=1, index 1 -> TICK_DIV=4
  logic [63:0] m_time  [2];
  logic [63:0] m_cmp   [2];
  int          m_since [2];
  logic        m_mtip  [2];

  ysyx_041514_clint_if bus1 ();
  ysyx_041514_clint_if bus4 ();

  assign bus1.clint_addr_i        = addr;
  assign bus1.clint_valid_i       = valid;
  assign bus1.clint_write_valid_i = wv;
  assign bus1.clint_wdata_i       = wdata;
  assign bus4.clint_addr_i        = addr;
  assign bus4.clint_valid_i       = valid;
  assign bus4.clint_write_valid_i = wv;
  assign bus4.clint_wdata_i       = wdata;

  ysyx_041514_clint #(.TICK_DIV(1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus1.slave),
    .mtip_o  (mtip1),
    .mtime_o (mtime1)
  );

  ysyx_041514_clint #(.TICK_DIV(4)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus4.slave),
    .mtip_o  (mtip4),
    .mtime_o (mtime4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc_n, obs, exp);
    end
  endtask

  function automatic int div_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_time[k]  = 64'd0;
      m_cmp[k]   = ONES;
      m_since[k] = 0;
      m_mtip[k]  = 1'b0;
    end
  endtask

  // Advance the reference by one clock edge using the request currently presented.
  task automatic model_edge();
    logic nxt_irq;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      nxt_irq = (m_time[k] >= m_cmp[k]);
      if (valid && wv && addr == MT) begin
        m_time[k]  = wdata;
        m_since[k] = 0;
      end else begin
        m_since[k] = m_since[k] + 1;
        if (m_since[k] == div_of(k)) begin
          m_time[k]  = m_time[k] + 64'd1;
          m_since[k] = 0;
        end
      end
      if (valid && wv && addr == MC) m_cmp[k] = wdata;
      m_mtip[k] = nxt_irq;
    end
  endtask

  function automatic logic [63:0] exp_rdata(input int k);
    if (rst) return 64'd0;
    if (valid && addr == MT) return m_time[k];
    if (valid && addr == MC) return m_cmp[k];
    return 64'd0;
  endfunction

  task automatic check_outputs();
    logic [63:0] e1, e4;
    e1 = exp_rdata(0);
    e4 = exp_rdata(1);
    if (rst) begin
      e1 = (valid && addr == MT) ? 64'd0 : (valid && addr == MC) ? ONES : 64'd0;
      e4 = e1;
    end
    chk("rdata_div1", bus1.clint_rdata_o, e1);
    chk("rdata_div4", bus4.clint_rdata_o, e4);
    chk("mtime_div1", mtime1, m_time[0]);
    chk("mtime_div4", mtime4, m_time[1]);
    chk("mtip_div1",  {63'd0, mtip1}, {63'd0, m_mtip[0]});
    chk("mtip_div4",  {63'd0, mtip4}, {63'd0, m_mtip[1]});
  endtask

  // One cycle: present request after negedge, check before posedge, then step the model.
  task automatic cyc(input logic [31:0] a, input logic v, input logic w, input logic [63:0] d);
    addr  = a;
    valid = v;
    wv    = w;
    wdata = d;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(MC, 1'b1, 1'b0, 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [63:0] rd;
    int          sel;
    n_cmp = 0;
    n_err = 0;
    cyc_n = 0;
    rst   = 1'b1;
    addr  = 32'd0;
    valid = 1'b0;
    wv    = 1'b0;
    wdata = 64'd0;
    model_reset();
    @(negedge clk);

    // Reset held for 3 cycles, reading mtimecmp
    for (int i = 0; i < 3; i++) cyc(MC, 1'b1, 1'b0, 64'd0);
    rst = 1'b0;
    chk("rst_mtime_const", mtime1, 64'd0);
    idle(3);

    // mtimecmp = 5, watch mtip rise and stay high
    cyc(MC, 1'b1, 1'b1, 64'd5);
    idle(12);
    chk("mtip_level_div1", {63'd0, mtip1}, 64'd1);

    // Wrap-around of mtime
    cyc(MT, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    idle(4);
    cyc(MC, 1'b1, 1'b1, ONES);
    idle(3);

    // Same-cycle read/write of mtime returns the old value
    cyc(MT, 1'b1, 1'b1, 64'd100);
    chk("wr_no_inc_div1", mtime1, 64'd100);
    idle(2);

    // Mid-period mtime write restarts the TICK_DIV=4 prescaler
    idle(2);
    cyc(MT, 1'b1, 1'b1, 64'd200);
    for (int i = 0; i < 9; i++) cyc(MT, 1'b1, 1'b0, 64'd0);

    // Unmapped address: load then store
    cyc(NONE, 1'b1, 1'b0, 64'd0);
    cyc(NONE, 1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0);
    idle(2);

    // Async reset mid-count takes effect before any clock edge
    cyc(MC, 1'b1, 1'b1, 64'd210);
    idle(3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_mtime1", mtime1, 64'd0);
    chk("async_rst_mtime4", mtime4, 64'd0);
    chk("async_rst_mtip1",  {63'd0, mtip1}, 64'd0);
    model_reset();
    @(negedge clk);
    cyc(MC, 1'b1, 1'b0, 64'd0);
    rst = 1'b0;
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: ra = MT;
        3, 4, 5: ra = MC;
        6:       ra = NONE;
        default: ra = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) rd = {$urandom, $urandom};
      else                           rd = m_time[0] + 64'($urandom_range(0, 20)) - 64'd5;
      cyc(ra, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
